// File: rtl/rom_tone_player.sv
// rom_tone_player: steps through the tone ROM one address at a time and
// plays each fetched word as a fixed-length square-wave note on beep.
//
// Ports:
//   sclk  - system clock, all logic on the rising edge
//   rst   - synchronous reset, active-high
//   start - one-cycle request to play from address 0 (honoured in IDLE only)
//   stop  - abort playback (FETCH/PLAY), highest priority after rst
//   loop  - sampled at the end of the last note: 1 restarts at address 0
//   addr  - registered ROM address, never exceeds DEPTH-1
//   data  - ROM word: tone half-period code, 0 = rest
//   beep  - registered square-wave tone output
//   busy  - high while in FETCH or PLAY
//   done  - one-cycle pulse when a non-looped melody completes
module rom_tone_player #(
   parameter int unsigned DEPTH       = 700,
   parameter int unsigned ROM_LAT     = 1,
   parameter int unsigned NOTE_CYCLES = 12500000,
   parameter int unsigned HALF_SCALE  = 50
) (
   input  logic        sclk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic        loop,
   output logic [15:0] addr,
   input  logic [10:0] data,
   output logic        beep,
   output logic        busy,
   output logic        done
);

   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned FW    = $clog2(ROM_LAT + 2);
   localparam int unsigned DW    = $clog2(NOTE_CYCLES + 1);
   // Full-width half-period product: 11 data bits plus the scale width.
   localparam int unsigned HW    = 11 + $clog2(HALF_SCALE + 1);

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
   localparam logic [FW-1:0] FETCH_END = FW'(ROM_LAT);
   localparam logic [DW-1:0] NOTE_END = DW'(NOTE_CYCLES - 1);
   localparam logic [HW-1:0] HS = HW'(HALF_SCALE);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      PLAY
   } state_t;

   state_t        state, state_n;
   logic [AW-1:0] idx, idx_n;
   logic [FW-1:0] fcnt, fcnt_n;
   logic [DW-1:0] dcnt, dcnt_n;
   logic [HW-1:0] tcnt, tcnt_n;
   logic [10:0]   note, note_n;
   logic          beep_n;
   logic          done_n;
   logic [HW-1:0] half;

   assign half = HW'(note) * HS;

   always_ff @(posedge sclk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         fcnt  <= '0;
         dcnt  <= '0;
         tcnt  <= '0;
         note  <= '0;
         beep  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         fcnt  <= fcnt_n;
         dcnt  <= dcnt_n;
         tcnt  <= tcnt_n;
         note  <= note_n;
         beep  <= beep_n;
         done  <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      fcnt_n  = fcnt;
      dcnt_n  = dcnt;
      tcnt_n  = tcnt;
      note_n  = note;
      beep_n  = beep;
      done_n  = 1'b0;

      case (state)
         IDLE: begin
            idx_n  = '0;
            beep_n = 1'b0;
            if (start && !stop) begin
               state_n = FETCH;
               fcnt_n  = '0;
            end
         end

         FETCH: begin
            beep_n = 1'b0;
            if (stop) begin
               state_n = IDLE;
               idx_n   = '0;
            end else if (fcnt == FETCH_END) begin
               // ROM output is valid for the held address by now.
               note_n  = data;
               state_n = PLAY;
               dcnt_n  = '0;
               tcnt_n  = '0;
            end else begin
               fcnt_n = fcnt + 1'b1;
            end
         end

         PLAY: begin
            if (stop) begin
               state_n = IDLE;
               idx_n   = '0;
               beep_n  = 1'b0;
            end else if (dcnt == NOTE_END) begin
               beep_n = 1'b0;
               fcnt_n = '0;
               if (idx != LAST_IDX) begin
                  idx_n   = idx + 1'b1;
                  state_n = FETCH;
               end else if (loop) begin
                  idx_n   = '0;
                  state_n = FETCH;
               end else begin
                  idx_n   = '0;
                  state_n = IDLE;
                  done_n  = 1'b1;
               end
            end else begin
               dcnt_n = dcnt + 1'b1;
               if (note != '0) begin
                  if (tcnt == half - HW'(1)) begin
                     tcnt_n = '0;
                     beep_n = ~beep;
                  end else begin
                     tcnt_n = tcnt + 1'b1;
                  end
               end
            end
         end

         default: begin
            state_n = IDLE;
            idx_n   = '0;
            beep_n  = 1'b0;
         end
      endcase
   end

   assign addr = 16'(idx);
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_rom_tone_player.sv
module tb_rom_tone_player;

   logic        sclk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        loop = 1'b0;
   logic [15:0] addr;
   logic [10:0] data = '0;
   logic        beep;
   logic        busy;
   logic        done;

   int total = 0;
   int bad = 0;

   int rom_w [4] = '{3, 0, 5, 1};

   always #5 sclk = ~sclk;

   // Registered 1-cycle ROM model.
   always_ff @(posedge sclk) data <= 11'(rom_w[addr[1:0]]);

   rom_tone_player #(
      .DEPTH(4),
      .ROM_LAT(1),
      .NOTE_CYCLES(20),
      .HALF_SCALE(1)
   ) dut (
      .sclk(sclk),
      .rst(rst),
      .start(start),
      .stop(stop),
      .loop(loop),
      .addr(addr),
      .data(data),
      .beep(beep),
      .busy(busy),
      .done(done)
   );

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".addr"}, int'(addr), 0);
      check({tag, ".beep"}, int'(beep), 0);
      check({tag, ".busy"}, int'(busy), 0);
      check({tag, ".done"}, int'(done), 0);
   endtask

   // Checks every cycle of the melody starting at the first FETCH cycle.
   // Each note: 2 FETCH cycles then 20 PLAY cycles; in PLAY cycle k the
   // tone for word w is floor(k/w) mod 2 (0 for a rest).
   task automatic run_melody(input int passes, input bit expect_done,
                             input bit poke_start, input int abort_note,
                             input int abort_k, input bit abort_rst);
      for (int p = 0; p < passes; p++) begin
         for (int n = 0; n < 4; n++) begin
            for (int j = 0; j < 22; j++) begin
               int k;
               int exp_beep;
               k = j - 2;
               exp_beep = (j < 2 || rom_w[n] == 0) ? 0 : (k / rom_w[n]) % 2;
               check("addr", int'(addr), n);
               check("beep", int'(beep), exp_beep);
               check("busy", int'(busy), 1);
               check("done", int'(done), 0);
               if (n == abort_note && j == 2 + abort_k) begin
                  if (abort_rst) rst = 1'b1;
                  else stop = 1'b1;
                  tick();
                  rst = 1'b0;
                  stop = 1'b0;
                  check_idle("abort");
                  for (int q = 0; q < 3; q++) begin
                     tick();
                     check_idle("post_abort");
                  end
                  return;
               end
               start = poke_start && (j == 0 || j == 15);
               tick();
               start = 1'b0;
            end
         end
      end
      if (expect_done) begin
         check("end.done", int'(done), 1);
         check("end.busy", int'(busy), 0);
         check("end.addr", int'(addr), 0);
         check("end.beep", int'(beep), 0);
         tick();
         check("after.done", int'(done), 0);
         check("after.busy", int'(busy), 0);
      end else begin
         check("wrap.addr", int'(addr), 0);
         check("wrap.busy", int'(busy), 1);
         check("wrap.done", int'(done), 0);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      // 1: reset and quiet idle
      rst = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      rst = 1'b0;
      check_idle("reset");
      for (int i = 0; i < 5; i++) begin
         tick();
         check_idle("idle");
      end

      // 2: one-shot playback
      loop = 1'b0;
      pulse_start();
      run_melody(1, 1'b1, 1'b0, -1, 0, 1'b0);

      // 3: looped playback, three passes, then stop
      loop = 1'b1;
      pulse_start();
      run_melody(3, 1'b0, 1'b0, -1, 0, 1'b0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check_idle("loop_stop");
      loop = 1'b0;

      // 4: stop at PLAY cycle 10 of address 2
      pulse_start();
      run_melody(1, 1'b0, 1'b0, 2, 10, 1'b0);

      // 5a: start with stop in the same idle cycle
      start = 1'b1;
      stop = 1'b1;
      tick();
      start = 1'b0;
      stop = 1'b0;
      check_idle("start_stop");
      tick();
      check_idle("start_stop2");

      // 5b: start pulses while busy do not disturb playback
      pulse_start();
      run_melody(1, 1'b1, 1'b1, -1, 0, 1'b0);

      // 6: reset during address 1 PLAY, then a fresh run
      pulse_start();
      run_melody(1, 1'b0, 1'b0, 1, 5, 1'b1);
      pulse_start();
      run_melody(1, 1'b1, 1'b0, -1, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rom_tone_player.md
Name: rom_tone_player

Overview:
- Sequencer that drives the address side of the 11x700 tone ROM and turns each fetched word into a square-wave beep for the pwm_beep design.
- Walks ROM addresses 0..DEPTH-1 and plays each word as one fixed-length note.
- Supports one-shot or looped playback, plus abort.
- Sits between the ROM instance and the buzzer pin.

Parameters:
DEPTH, 700, number of ROM words in the melody; last address is DEPTH-1
ROM_LAT, 1, ROM read latency in clocks from addr change to valid data
NOTE_CYCLES, 12500000, clocks each note is played (250 ms at 50 MHz)
HALF_SCALE, 50, clocks per data LSB for the tone half-period (HALF_SCALE >= 1)

Ports:
sclk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle request to begin playback from address 0; honoured only in IDLE
stop  input  1  abort playback; highest priority after rst
loop  input  1  sampled at end of last note: 1 = restart at address 0, 0 = finish
addr  output  16  ROM address, registered
data  input  11  ROM word: tone half-period code; 0 = rest (silence)
beep  output  1  square-wave tone output, registered
busy  output  1  high in FETCH and PLAY
done  output  1  one-cycle pulse when a non-looped melody completes

Behaviour:
- Reset (rst=1 at an edge, any state):
  - state IDLE; addr=0, beep=0, busy=0, done=0.
  - All counters cleared.
  - Reset mid-play aborts immediately with no done pulse.
- States: IDLE, FETCH, PLAY.
- IDLE:
  - addr=0, beep=0, busy=0.
  - start=1 and stop=0 -> FETCH; busy=1 from the next cycle.
  - start with stop in the same cycle -> stay IDLE.
- FETCH:
  - Lasts exactly ROM_LAT+1 cycles with addr held stable; beep=0 throughout (inter-note gap).
  - On the edge leaving FETCH, data is captured into note_reg -> PLAY.
- PLAY:
  - Duration counter runs 0..NOTE_CYCLES-1.
  - Tone counter and beep are 0 on entry.
  - note_reg=0: beep held 0 for the whole note.
  - note_reg!=0: tone counter runs 0..note_reg*HALF_SCALE-1, then beep toggles and the counter restarts.
    - Period = 2*note_reg*HALF_SCALE clocks.
    - First toggle occurs note_reg*HALF_SCALE cycles after PLAY entry.
  - The product note_reg*HALF_SCALE is computed at full width (11 + clog2(HALF_SCALE+1) bits); no truncation.
- End of note (duration counter = NOTE_CYCLES-1):
  - beep forced 0 on that edge.
  - addr < DEPTH-1: addr+1 -> FETCH.
  - addr = DEPTH-1 and loop=1: addr=0 -> FETCH; no done pulse.
  - addr = DEPTH-1 and loop=0: -> IDLE, addr=0, busy=0, done=1 for exactly one cycle.
- addr never exceeds DEPTH-1; upper address bits beyond the needed width are 0.
- stop=1 in FETCH or PLAY:
  - Next edge -> IDLE, addr=0, beep=0, busy=0.
  - done stays 0.
  - stop in IDLE has no effect.
- start while busy=1 is ignored; no restart.
- Per-note time = ROM_LAT+1+NOTE_CYCLES clocks.
- Total one-shot busy time = DEPTH*(ROM_LAT+1+NOTE_CYCLES) clocks.

Test Plan:
Bench configuration for all scenarios:
- DEPTH=4, ROM_LAT=1, NOTE_CYCLES=20, HALF_SCALE=1.
- Bench ROM model with registered 1-cycle output, contents {3,0,5,1}.

1. Hold rst=1 for 3 cycles, then release -> addr=0, beep=0, busy=0, done=0; stays IDLE with no start.
2. start pulse, loop=0 ->
   - addr steps 0,1,2,3, each held 22 cycles.
   - Word 3: beep toggles every 3 cycles (period 6).
   - Word 0: beep stays 0 for all 20 PLAY cycles.
   - Word 5: period 10. Word 1: period 2.
   - busy high exactly 88 cycles, then done=1 for one cycle with busy=0 and addr=0.
3. loop=1, start -> after the addr=3 note, addr returns to 0 and playback continues; done never asserts; busy stays 1 through 3 full passes.
4. start, then stop=1 for one cycle at cycle 10 of the addr=2 PLAY -> next cycle IDLE, beep=0, addr=0, busy=0, no done pulse.
5. Contention cases:
   - start and stop in the same cycle while IDLE -> remains IDLE.
   - start pulses while busy -> addr sequence and timing identical to scenario 2.
6. rst=1 asserted during the addr=1 PLAY -> next edge all outputs 0 and IDLE; a fresh start afterwards replays from addr=0 with scenario 2 timing.
